// File: rtl/lzs_pkg.sv
// Shared constants, state encoding and token prefix codes for the LZS decompressor.
package lzs_pkg;

  localparam int HIST_AW        = 11;
  localparam int IN_WIDTH       = 13;
  localparam int NEED_STR_WIDTH = 4;
  localparam int BUF_W          = 128;
  localparam int CNT_W          = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_LIT,
    ST_OFFS,
    ST_LEN,
    ST_LENX,
    ST_COPY,
    ST_DONE
  } lzs_state_e;

  localparam logic       PFX_LIT    = 1'b0;
  localparam logic [1:0] PFX_SHORT  = 2'b11;
  localparam logic [1:0] PFX_LONG   = 2'b10;
  localparam int         END_OFFSET = 0;

  // 2-bit length codes map to 2..4, 4-bit codes to 5..7, escape starts at 8.
  localparam logic [15:0] LEN_MIN = 16'd2;
  localparam logic [15:0] LEN_MID = 16'd5;
  localparam logic [15:0] LEN_EXT = 16'd8;
  localparam logic [3:0]  EXT_NIBBLE = 4'hF;

endpackage

// File: rtl/lzs_decoder_if.sv
// Stream-side signal bundle of the LZS decoder (FIFO input, byte output).
// Optional out_cnt present when LZS_OUTCNT_EN is defined.
interface lzs_decoder_if;
  logic        fo_full;
  logic        src_empty;
  logic        m_last;
  logic [63:0] fi;
  logic        m_src_getn;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_done;
`ifdef LZS_OUTCNT_EN
  logic [19:0] out_cnt;
`endif

  modport slave (
    input  fo_full, src_empty, m_last, fi,
`ifdef LZS_OUTCNT_EN
    output out_cnt,
`endif
    output m_src_getn, out_data, out_valid, out_done
  );

  modport master (
    output fo_full, src_empty, m_last, fi,
`ifdef LZS_OUTCNT_EN
    input  out_cnt,
`endif
    input  m_src_getn, out_data, out_valid, out_done
  );
endinterface

// File: rtl/lzs_bitwin.sv
// Bit unpacker: pops 64-bit words into an MSB-aligned buffer, exposes a
// 13-bit peek window and drops the acknowledged number of bits each cycle.
module lzs_bitwin
  import lzs_pkg::*;
#(
  parameter int IN_W = IN_WIDTH,
  parameter int NW   = NEED_STR_WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            halt,
  input  logic            src_empty,
  input  logic            m_last,
  input  logic [63:0]     fi,
  output logic            src_getn,
  output logic [IN_W-1:0] stream_data,
  output logic            stream_valid,
  output logic            stream_last,
  output logic [NW-1:0]   stream_bits,
  input  logic [NW-1:0]   stream_width
);

  logic [BUF_W-1:0] bits_q, bits_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, kept;
  logic             last_q, last_d;
  logic             pop;

  always_comb begin
    pop    = en && !halt && !last_q && !src_empty && (cnt_q < CNT_W'(64));
    kept   = cnt_q - CNT_W'(stream_width);
    bits_d = bits_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (en) begin
      bits_d = bits_q << stream_width;
      cnt_d  = kept;
      // New word lands right behind the bits that survive this cycle's ack.
      if (pop) begin
        bits_d = bits_d | ({fi, 64'd0} >> kept);
        cnt_d  = kept + CNT_W'(64);
        last_d = m_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bits_q <= '0;
      cnt_q  <= '0;
      last_q <= 1'b0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  assign src_getn     = !pop;
  assign stream_data  = bits_q[BUF_W-1 -: IN_W];
  assign stream_last  = last_q;
  assign stream_valid = (cnt_q >= CNT_W'(IN_W)) || (last_q && (cnt_q != '0));
  assign stream_bits  = (cnt_q >= CNT_W'(IN_W)) ? NW'(IN_W) : cnt_q[NW-1:0];

endmodule

// File: rtl/lzs_decoder.sv
// LZS decompressor top: token FSM plus 2^HIST_AW-byte history window.
// Define LZS_OUTCNT_EN to add the out_cnt emitted-byte counter.
module lzs_decoder
  import lzs_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  lzs_decoder_if.slave bus
);

  lzs_state_e                state_q, state_d;
  logic [7:0]                lit_q, lit_d;
  logic [7:0]                last_byte_q, last_byte_d;
  logic [HIST_AW-1:0]        off_q, off_d;
  logic [HIST_AW-1:0]        wp_q, wp_d;
  logic [15:0]               len_q, len_d;
  logic                      done_q, done_d;
  logic [HIST_AW-1:0]        rd_addr;
  logic [7:0]                rd_q;
  logic                      en, emit, out_valid;
  logic [7:0]                emit_byte;
  logic [IN_WIDTH-1:0]       sd;
  logic                      s_valid, s_last;
  logic [NEED_STR_WIDTH-1:0] s_bits, ack, s_width;
  logic                      have2, have4, have9, have13;

  logic [7:0] hist_mem [0:(1<<HIST_AW)-1];

  assign en      = ce && !bus.fo_full;
  assign s_width = en ? ack : '0;

  lzs_bitwin u_bitwin (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .halt         ((state_q == ST_IDLE) || (state_q == ST_DONE)),
    .src_empty    (bus.src_empty),
    .m_last       (bus.m_last),
    .fi           (bus.fi),
    .src_getn     (bus.m_src_getn),
    .stream_data  (sd),
    .stream_valid (s_valid),
    .stream_last  (s_last),
    .stream_bits  (s_bits),
    .stream_width (s_width)
  );

  assign have2  = s_valid && (s_bits >= NEED_STR_WIDTH'(2));
  assign have4  = s_valid && (s_bits >= NEED_STR_WIDTH'(4));
  assign have9  = s_valid && (s_bits >= NEED_STR_WIDTH'(9));
  assign have13 = s_valid && (s_bits >= NEED_STR_WIDTH'(13));

  // Any field that cannot complete once the last word is in means truncation.
  always_comb begin
    state_d   = state_q;
    lit_d     = lit_q;
    off_d     = off_q;
    len_d     = len_q;
    ack       = '0;
    emit      = 1'b0;
    emit_byte = 8'h00;
    case (state_q)
      ST_IDLE: state_d = ST_TOKEN;
      ST_TOKEN: begin
        if (sd[12] != PFX_LIT) begin
          state_d = ST_OFFS;
        end else if (have9) begin
          ack     = NEED_STR_WIDTH'(9);
          lit_d   = sd[11:4];
          state_d = ST_LIT;
        end else if (s_last) begin
          state_d = ST_DONE;
        end
      end
      ST_LIT: begin
        emit      = 1'b1;
        emit_byte = lit_q;
        state_d   = ST_TOKEN;
      end
      ST_OFFS: begin
        if (sd[12:11] == PFX_SHORT) begin
          if (have9) begin
            ack     = NEED_STR_WIDTH'(9);
            off_d   = HIST_AW'(sd[10:4]);
            state_d = (sd[10:4] == 7'(END_OFFSET)) ? ST_DONE : ST_LEN;
          end else if (s_last) begin
            state_d = ST_DONE;
          end
        end else if (sd[12:11] == PFX_LONG) begin
          if (have13) begin
            ack     = NEED_STR_WIDTH'(13);
            off_d   = HIST_AW'(sd[10:0]);
            state_d = ST_LEN;
          end else if (s_last) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LEN: begin
        if (sd[12:11] != 2'b11) begin
          if (have2) begin
            ack     = NEED_STR_WIDTH'(2);
            len_d   = LEN_MIN + 16'(sd[12:11]);
            state_d = ST_COPY;
          end else if (s_last) begin
            state_d = ST_DONE;
          end
        end else if (have4) begin
          ack = NEED_STR_WIDTH'(4);
          if (sd[10:9] != 2'b11) begin
            len_d   = LEN_MID + 16'(sd[10:9]);
            state_d = ST_COPY;
          end else begin
            len_d   = LEN_EXT;
            state_d = ST_LENX;
          end
        end else if (s_last) begin
          state_d = ST_DONE;
        end
      end
      ST_LENX: begin
        if (have4) begin
          ack   = NEED_STR_WIDTH'(4);
          len_d = len_q + 16'(sd[12:9]);
          if (sd[12:9] != EXT_NIBBLE) state_d = ST_COPY;
        end else if (s_last) begin
          state_d = ST_DONE;
        end
      end
      ST_COPY: begin
        // Offset 1 reads the byte written at the same edge as the RAM read.
        emit      = 1'b1;
        emit_byte = (off_q == HIST_AW'(1)) ? last_byte_q : rd_q;
        len_d     = len_q - 16'd1;
        if (len_q == 16'd1) state_d = ST_TOKEN;
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done_d      = done_q | (state_d == ST_DONE);
    wp_d        = wp_q + HIST_AW'(emit);
    last_byte_d = emit ? emit_byte : last_byte_q;
    // Prefetch the source of the next byte to be emitted.
    rd_addr     = wp_q - off_q + ((state_q == ST_COPY) ? HIST_AW'(1) : '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      lit_q       <= '0;
      last_byte_q <= '0;
      off_q       <= '0;
      wp_q        <= '0;
      len_q       <= '0;
      done_q      <= 1'b0;
    end else if (en) begin
      state_q     <= state_d;
      lit_q       <= lit_d;
      last_byte_q <= last_byte_d;
      off_q       <= off_d;
      wp_q        <= wp_d;
      len_q       <= len_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      if (emit) hist_mem[wp_q] <= emit_byte;
      rd_q <= hist_mem[rd_addr];
    end
  end

  assign out_valid     = emit && en;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? emit_byte : 8'h00;
  assign bus.out_done  = done_q;

`ifdef LZS_OUTCNT_EN
  logic [19:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && !done_q) cnt_d = cnt_q + 20'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign bus.out_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_lzs_decoder.sv
// Directed bench for lzs_decoder: hand-encoded LZS streams, expected bytes
// written out explicitly per case.
module tb_lzs_decoder;

  logic clk = 1'b0;
  logic rst;
  logic ce;

  always #5 clk = ~clk;

  lzs_decoder_if bus ();

  lzs_decoder dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  logic [63:0] words [0:63];
  int          nwords = 0;
  int          rd_idx = 0;

  assign bus.fi        = words[rd_idx[5:0]];
  assign bus.src_empty = (rd_idx >= nwords);
  assign bus.m_last    = (rd_idx == nwords - 1);

  always @(posedge clk or negedge rst) begin
    if (!rst)                 rd_idx <= 0;
    else if (!bus.m_src_getn) rd_idx <= rd_idx + 1;
  end

  bit         bitq [$];
  logic [7:0] exp_q [$];
  logic [7:0] got_q [$];
  int         cyc_q [$];
  int         n_chk = 0;
  int         n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic put(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
  endtask

  task automatic lit(input int b);
    put(0, 1);
    put(b, 8);
  endtask

  task automatic end_mark();
    put(3, 2);
    put(0, 7);
  endtask

  task automatic pack();
    logic [63:0] w;
    nwords = 0;
    while (bitq.size() > 0 && nwords < 64) begin
      w = '0;
      for (int b = 63; b >= 0; b--)
        if (bitq.size() > 0) w[b] = bitq.pop_front();
      words[nwords] = w;
      nwords++;
    end
  endtask

  task automatic start_case();
    rst = 1'b0;
    ce  = 1'b1;
    bus.fo_full = 1'b0;
    bitq.delete();
    exp_q.delete();
  endtask

  task automatic build_ab();
    lit(8'h61);
    lit(8'h62);
    put(3, 2); put(2, 7);   // short offset 2
    put(2, 2);              // length 4
    end_mark();
    pack();
  endtask

  task automatic build_rle();
    lit(8'h55);
    put(3, 2); put(1, 7);   // short offset 1
    put(15, 4); put(15, 4); put(0, 4);   // length 8 + 15 + 0 = 23
    end_mark();
    pack();
  endtask

  task automatic run(input string tag, input int stall, input int max_cyc);
    int cyc;
    int leak;
    int extra;
    logic [31:0] g;
    cyc = 0; leak = 0; extra = 0;
    got_q.delete();
    cyc_q.delete();
    @(negedge clk);
    rst = 1'b1;
    while (cyc < max_cyc && !bus.out_done) begin
      @(negedge clk);
      if (stall != 0) begin
        ce          = (((cyc / 5) % 2) == 0);
        bus.fo_full = (((cyc / 3) % 2) == 1);
      end
      #1;
      if (bus.out_valid) begin
        got_q.push_back(bus.out_data);
        cyc_q.push_back(cyc);
        if (!ce || bus.fo_full) leak++;
      end
      cyc++;
    end
    ce = 1'b1;
    bus.fo_full = 1'b0;
    chk({tag, " done"}, {31'd0, bus.out_done}, 32'd1);
    chk({tag, " count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hDEAD_BEEF;
      chk($sformatf("%s byte%0d", tag, i), g, {24'd0, exp_q[i]});
    end
    if (stall != 0) chk({tag, " stall_leak"}, leak, 0);
    repeat (8) begin
      @(negedge clk);
      #1;
      if (bus.out_valid || !bus.out_done) extra++;
    end
    chk({tag, " sticky"}, extra, 0);
`ifdef LZS_OUTCNT_EN
    chk({tag, " out_cnt"}, {12'd0, bus.out_cnt}, exp_q.size());
`endif
    $display("case %s: %0d bytes in %0d cycles", tag, got_q.size(), cyc);
  endtask

  initial begin
    int seen;
    int cyc;
    rst = 1'b1;
    ce  = 1'b1;
    bus.fo_full = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk("reset getn", {31'd0, bus.m_src_getn}, 32'd1);
    chk("reset valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset data", {24'd0, bus.out_data}, 32'd0);
    chk("reset done", {31'd0, bus.out_done}, 32'd0);

    // literal 'A' then end marker
    start_case();
    lit(8'h41);
    end_mark();
    pack();
    exp_q = '{8'h41};
    run("lit_end", 0, 200);

    // overlapping copy: a b + (off 2, len 4)
    start_case();
    build_ab();
    exp_q = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h61, 8'h62};
    run("overlap", 0, 200);

    // run-length: 0x55 + (off 1, len 23)
    start_case();
    build_rle();
    for (int i = 0; i < 24; i++) exp_q.push_back(8'h55);
    run("rle", 0, 300);
    chk("rle copy span", (cyc_q.size() >= 24) ? (cyc_q[23] - cyc_q[1]) : -1, 22);

    // 300 literals then long offset 300, length 5 (code 1100)
    start_case();
    for (int i = 0; i < 300; i++) begin
      lit(i % 256);
      exp_q.push_back(8'(i % 256));
    end
    put(2, 2); put(300, 11);
    put(12, 4);
    end_mark();
    pack();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(i));
    run("long_off", 0, 2000);

    // overlap case again under fo_full / ce toggling
    start_case();
    build_ab();
    exp_q = '{8'h61, 8'h62, 8'h61, 8'h62, 8'h61, 8'h62};
    run("stall", 1, 600);

    // truncated: 7 literals fill 63 bits of the only (last) word, no end marker
    start_case();
    for (int i = 0; i < 7; i++) begin
      lit(8'h10 + i);
      exp_q.push_back(8'(8'h10 + i));
    end
    put(0, 1);
    pack();
    run("trunc", 0, 200);

    // reset dropped in the middle of a copy
    start_case();
    build_rle();
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    cyc  = 0;
    while (seen < 10 && cyc < 200) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) seen++;
      cyc++;
    end
    chk("rst_mid seen", seen, 10);
    chk("rst_mid pre_valid", {31'd0, bus.out_valid}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid data", {24'd0, bus.out_data}, 32'd0);
    chk("rst_mid done", {31'd0, bus.out_done}, 32'd0);
    chk("rst_mid getn", {31'd0, bus.m_src_getn}, 32'd1);
    $display("case rst_mid: reset after %0d bytes", seen);

    // recovery after the abort
    start_case();
    lit(8'h41);
    end_mark();
    pack();
    exp_q = '{8'h41};
    run("recover", 0, 200);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
